// File: rtl/decode_unit.sv
// RV32I decode stage: IF/ID pipeline register, 32-entry register file, field/immediate decode.
// Optional macro WB_BYPASS_EN forwards the same-cycle writeback value to register reads.
module decode_unit #(
  parameter int word_size = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [word_size-1:0] instruction,
  input  logic [word_size-1:0] PC_next_normal,
  input  logic                 valid_in,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 RegWrite_wb,
  input  logic [4:0]           rd_wb,
  input  logic [word_size-1:0] write_data_wb,
  output logic [word_size-1:0] rs1_data,
  output logic [word_size-1:0] rs2_data,
  output logic [word_size-1:0] imm,
  output logic [6:0]           opcode,
  output logic [4:0]           rd,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2,
  output logic [2:0]           funct3,
  output logic [6:0]           funct7,
  output logic [word_size-1:0] PC_out,
  output logic                 valid_out,
  output logic                 illegal
);

  localparam logic [word_size-1:0] NOP = word_size'(32'h0000_0013);

  logic [word_size-1:0] instr_q;
  logic [word_size-1:0] pc_q;
  logic                 valid_q;
  logic [word_size-1:0] regs [32];
  logic [31:0]          iw;
  logic [31:0]          imm32;

  // Squashed slots become a NOP but keep their PC
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else if (!stall) begin
      instr_q <= instruction;
      pc_q    <= PC_next_normal;
      valid_q <= valid_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (RegWrite_wb && (rd_wb != 5'd0)) begin
      regs[rd_wb] <= write_data_wb;
    end
  end

  function automatic logic [word_size-1:0] read_port(input logic [4:0] addr);
    logic [word_size-1:0] value;
    if (addr == 5'd0) begin
      value = '0;
`ifdef WB_BYPASS_EN
    end else if (RegWrite_wb && (rd_wb == addr)) begin
      value = write_data_wb;
`endif
    end else begin
      value = regs[addr];
    end
    return value;
  endfunction

  assign iw        = instr_q[31:0];
  assign opcode    = iw[6:0];
  assign rd        = iw[11:7];
  assign funct3    = iw[14:12];
  assign rs1       = iw[19:15];
  assign rs2       = iw[24:20];
  assign funct7    = iw[31:25];
  assign PC_out    = pc_q;
  assign valid_out = valid_q;

  always_comb begin
    rs1_data = read_port(rs1);
    rs2_data = read_port(rs2);
  end

  always_comb begin
    imm32 = '0;
    case (iw[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: imm32 = {{20{iw[31]}}, iw[31:20]};
      7'h23:                      imm32 = {{20{iw[31]}}, iw[31:25], iw[11:7]};
      7'h63:                      imm32 = {{19{iw[31]}}, iw[31], iw[7], iw[30:25], iw[11:8], 1'b0};
      7'h37, 7'h17:               imm32 = {iw[31:12], 12'h000};
      7'h6F:                      imm32 = {{11{iw[31]}}, iw[31], iw[19:12], iw[20], iw[30:21], 1'b0};
      default:                    imm32 = '0;
    endcase
    imm = word_size'($signed(imm32));
  end

  always_comb begin
    illegal = 1'b0;
    case (iw[6:0])
      7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
      7'h37, 7'h63, 7'h67, 7'h6F, 7'h73: illegal = 1'b0;
      default:                           illegal = valid_q;
    endcase
  end

endmodule

// File: tb/tb_decode_unit.sv
// Self-checking bench for decode_unit: directed scenarios plus randomized traffic
// compared against an arithmetic reference model of the decode stage.
module tb_decode_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic [31:0] PC_next_normal;
  logic        valid_in;
  logic        stall;
  logic        flush;
  logic        RegWrite_wb;
  logic [4:0]  rd_wb;
  logic [31:0] write_data_wb;
  logic [31:0] rs1_data, rs2_data, imm, PC_out;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        valid_out, illegal;

  int tests = 0;
  int fails = 0;

  longint unsigned m_instr, m_pc;
  bit              m_valid;
  longint unsigned m_regs [32];

  always #5 clk = ~clk;

  decode_unit #(.word_size(32)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .PC_next_normal(PC_next_normal),
    .valid_in(valid_in), .stall(stall), .flush(flush), .RegWrite_wb(RegWrite_wb),
    .rd_wb(rd_wb), .write_data_wb(write_data_wb), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .PC_out(PC_out), .valid_out(valid_out), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic bit bitAt(input longint unsigned w, input int pos);
    return bit'((w >> pos) & 1);
  endfunction

  // Immediate built from the RV32I bit placements with plain arithmetic
  function automatic logic [31:0] refImm(input longint unsigned w);
    longint v;
    longint unsigned op;
    op = w % 128;
    v = 0;
    if (op == 3 || op == 19 || op == 103 || op == 115) begin
      v = longint'((w >> 20) % 4096);
      if (bitAt(w, 31)) v = v - 4096;
    end else if (op == 35) begin
      v = longint'(((w >> 25) % 128) * 32 + ((w >> 7) % 32));
      if (bitAt(w, 31)) v = v - 4096;
    end else if (op == 99) begin
      v = longint'(bitAt(w, 31)) * 4096 + longint'(bitAt(w, 7)) * 2048
        + longint'((w >> 25) % 64) * 32 + longint'((w >> 8) % 16) * 2;
      if (bitAt(w, 31)) v = v - 8192;
    end else if (op == 55 || op == 23) begin
      v = longint'((w >> 12) * 4096);
    end else if (op == 111) begin
      v = longint'(bitAt(w, 31)) * (1 << 20) + longint'((w >> 12) % 256) * 4096
        + longint'(bitAt(w, 20)) * 2048 + longint'((w >> 21) % 1024) * 2;
      if (bitAt(w, 31)) v = v - (1 << 21);
    end
    return 32'(v);
  endfunction

  function automatic bit refLegal(input longint unsigned op);
    int legal [11] = '{3, 15, 19, 23, 35, 51, 55, 99, 103, 111, 115};
    foreach (legal[k]) if (op == longint'(legal[k])) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] refRead(input longint unsigned addr);
    if (addr == 0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (RegWrite_wb && longint'(rd_wb) == addr) return write_data_wb;
`endif
    return 32'(m_regs[addr]);
  endfunction

  task automatic checkOutput();
    chk("opcode",    32'(opcode),    32'(m_instr % 128));
    chk("rd",        32'(rd),        32'((m_instr >> 7) % 32));
    chk("funct3",    32'(funct3),    32'((m_instr >> 12) % 8));
    chk("rs1",       32'(rs1),       32'((m_instr >> 15) % 32));
    chk("rs2",       32'(rs2),       32'((m_instr >> 20) % 32));
    chk("funct7",    32'(funct7),    32'(m_instr >> 25));
    chk("imm",       imm,            refImm(m_instr));
    chk("rs1_data",  rs1_data,       refRead((m_instr >> 15) % 32));
    chk("rs2_data",  rs2_data,       refRead((m_instr >> 20) % 32));
    chk("PC_out",    PC_out,         32'(m_pc));
    chk("valid_out", 32'(valid_out), 32'(m_valid));
    chk("illegal",   32'(illegal),   32'(m_valid && !refLegal(m_instr % 128)));
  endtask

  task automatic modelUpdate();
    if (rst) begin
      m_instr = 32'h13; m_pc = 0; m_valid = 1'b0;
      foreach (m_regs[k]) m_regs[k] = 0;
    end else begin
      if (RegWrite_wb && rd_wb != 0) m_regs[rd_wb] = write_data_wb;
      if (flush) begin
        m_instr = 32'h13; m_valid = 1'b0;
      end else if (!stall) begin
        m_instr = instruction; m_pc = PC_next_normal; m_valid = valid_in;
      end
    end
  endtask

  task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] pc, input logic v);
    instruction = ins; PC_next_normal = pc; valid_in = v;
  endtask

  task automatic setControl(input logic s, input logic f, input logic r);
    stall = s; flush = f; rst = r;
  endtask

  task automatic setWrite(input logic we, input logic [4:0] a, input logic [31:0] d);
    RegWrite_wb = we; rd_wb = a; write_data_wb = d;
  endtask

  // Check against the model, clock once, advance the model
  task automatic cycle();
    #1;
    checkOutput();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  initial begin
    int legal_ops [11] = '{3, 15, 19, 23, 35, 51, 55, 99, 103, 111, 115};
    logic [31:0] w;
    m_instr = 32'h13; m_pc = 0; m_valid = 1'b0;
    foreach (m_regs[k]) m_regs[k] = 0;
    applyStimulus(32'h13, 32'h0, 1'b0);
    setControl(1'b0, 1'b0, 1'b1);
    setWrite(1'b0, 5'd0, 32'h0);
    @(posedge clk); modelUpdate(); #1;
    cycle();
    setControl(1'b0, 1'b0, 1'b0);
    repeat (3) cycle();
    chk("rst_valid_out", 32'(valid_out), 32'h0);
    chk("rst_opcode",    32'(opcode),    32'h13);
    chk("rst_PC_out",    PC_out,         32'h0);
    chk("rst_imm",       imm,            32'h0);
    chk("rst_illegal",   32'(illegal),   32'h0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus({7'h0, 5'(31 - i), 5'(i), 3'h0, 5'd1, 7'h33}, 32'(i * 4), 1'b1);
      cycle();
      chk("rst_reg_a", rs1_data, 32'h0);
      chk("rst_reg_b", rs2_data, 32'h0);
    end

    setWrite(1'b1, 5'd5, 32'hDEADBEEF);
    cycle();
    setWrite(1'b0, 5'd0, 32'h0);
    applyStimulus(32'h00528293, 32'h0000_0104, 1'b1);
    cycle();
    chk("addi_rs1",      32'(rs1), 32'd5);
    chk("addi_rd",       32'(rd),  32'd5);
    chk("addi_rs1_data", rs1_data, 32'hDEADBEEF);
    chk("addi_imm",      imm,      32'h5);
    chk("addi_PC_out",   PC_out,   32'h104);

    applyStimulus(32'hFE000EE3, 32'h200, 1'b1);
    cycle();
    chk("beq_imm", imm, 32'hFFFFFFFC);
    applyStimulus(32'h800000EF, 32'h204, 1'b1);
    cycle();
    chk("jal_imm", imm, 32'hFFF00000);

    applyStimulus(32'h00528293, 32'h300, 1'b1);
    cycle();
    applyStimulus(32'h00A00313, 32'h304, 1'b1);
    setControl(1'b1, 1'b0, 1'b0);
    cycle();
    cycle();
    chk("stall_rd",     32'(rd), 32'd5);
    chk("stall_PC_out", PC_out,  32'h300);
    setControl(1'b0, 1'b0, 1'b0);
    cycle();
    chk("unstall_rd",  32'(rd), 32'd6);
    chk("unstall_imm", imm,     32'hA);
    setControl(1'b1, 1'b1, 1'b0);
    cycle();
    chk("flush_valid",  32'(valid_out), 32'h0);
    chk("flush_opcode", 32'(opcode),    32'h13);
    chk("flush_PC_out", PC_out,         32'h304);
    setControl(1'b0, 1'b0, 1'b0);

    setWrite(1'b1, 5'd7, 32'h11111111);
    cycle();
    setWrite(1'b0, 5'd0, 32'h0);
    applyStimulus(32'h000380B3, 32'h400, 1'b1);
    cycle();
    setWrite(1'b1, 5'd7, 32'h12345678);
    #1;
`ifdef WB_BYPASS_EN
    chk("bypass_same_cycle", rs1_data, 32'h12345678);
`else
    chk("bypass_same_cycle", rs1_data, 32'h11111111);
`endif
    cycle();
    chk("bypass_next_cycle", rs1_data, 32'h12345678);
    setWrite(1'b1, 5'd0, 32'hFFFFFFFF);
    applyStimulus(32'h00000033, 32'h404, 1'b1);
    cycle();
    setWrite(1'b0, 5'd0, 32'h0);
    cycle();
    chk("x0_reads_zero", rs1_data, 32'h0);

    applyStimulus(32'h0000007F, 32'h500, 1'b1);
    cycle();
    chk("illegal_valid", 32'(illegal), 32'h1);
    applyStimulus(32'h0000007F, 32'h504, 1'b0);
    cycle();
    chk("illegal_invalid", 32'(illegal), 32'h0);

    setWrite(1'b1, 5'd9, 32'h0000AAAA);
    setControl(1'b1, 1'b0, 1'b1);
    cycle();
    setWrite(1'b0, 5'd0, 32'h0);
    setControl(1'b0, 1'b0, 1'b0);
    applyStimulus(32'h005480B3, 32'h600, 1'b1);
    cycle();
    chk("rst_over_write_x9", rs1_data, 32'h0);
    chk("rst_cleared_x5",    rs2_data, 32'h0);

    for (int n = 0; n < 400; n++) begin
      w = $urandom;
      case ($urandom_range(0, 3))
        0:       w[6:0] = $urandom_range(0, 127);
        1:       w[6:0] = 7'h7F;
        default: w[6:0] = 7'(legal_ops[$urandom_range(0, 10)]);
      endcase
      applyStimulus(w, $urandom, 1'($urandom_range(0, 1)));
      setControl($urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0);
      setWrite($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
